sweep_gen: RTL and testbench
============================

SWEEP_GEN -- requirements
Module: sweep_gen

Interface
REQ-001 SHALL have parameter INDEX_START, default 16'd1, meaning first FFT bin index of a sweep.
REQ-002 SHALL have parameter INDEX_STEP, default 16'd1, meaning bin increment per measurement point.
REQ-003 SHALL have parameter INDEX_MAX, default 16'd2751, meaning terminal bin index; must match the learn controller's limit.
REQ-004 SHALL have parameter PINC_PER_BIN, default 32'd34360, meaning phase increment per bin: 2^32 * 400 Hz / 50 MHz, rounded.
REQ-005 SHALL have port clk_50m, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port learn_en, input, 1 bit: sweep request from the 1.6384 MHz domain; asynchronous to clk_50m.
REQ-008 SHALL have port next_freq, input, 1 bit: point request from the 1.6384 MHz domain; asynchronous to clk_50m.
REQ-009 SHALL have port freq, output, 16 bits: current bin index, registered.
REQ-010 SHALL have port pinc, output, 32 bits: DDS phase increment, registered.
REQ-011 SHALL have port dds_addr, output, 10 bits: sine LUT address, equal to phase[31:22].
REQ-012 SHALL have port dds_en, output, 1 bit: excitation active.
REQ-013 SHALL have port sweep_done, output, 1 bit: level, asserted after the last point.

Function
REQ-014 SHALL pass learn_en and next_freq each through a two-flop synchronizer plus one history flop; edges are detected on the synchronized signals only.
REQ-015 SHALL implement the FSM states IDLE, ARM, RUN and DONE.
REQ-016 IDLE: freq=0, dds_en=0, phase held at 0. A learn_en rising edge moves the FSM to ARM.
REQ-017 ARM (exactly 1 cycle): freq<=INDEX_START, first_pt<=1; the FSM then moves to RUN.
REQ-018 RUN: dds_en=1 and phase<=phase+pinc every cycle, modulo 2^32.
REQ-019 In RUN, the first next_freq rising edge SHALL only clear first_pt and SHALL NOT change freq.
REQ-020 In RUN, each later next_freq rising edge:
- if freq+INDEX_STEP < INDEX_MAX: freq<=freq+INDEX_STEP;
- otherwise: freq<=INDEX_MAX and the FSM moves to DONE.
- The comparison SHALL use 17-bit arithmetic, so no wrap occurs.
REQ-021 pinc SHALL equal freq*PINC_PER_BIN truncated to 32 bits, updated exactly 1 cycle after freq changes; 16x32 multiply, lower 32 bits kept.
REQ-022 DONE: sweep_done=1, dds_en=0, phase cleared, freq held at INDEX_MAX; a learn_en falling edge moves the FSM to IDLE.
REQ-023 A learn_en falling edge in ARM or RUN (abort) SHALL move the FSM to IDLE next cycle; sweep_done stays 0.
REQ-024 A learn_en falling edge and a next_freq rising edge in the same cycle SHALL resolve as abort; freq does not step.
REQ-025 A next_freq edge in IDLE, ARM or DONE SHALL be ignored.
REQ-026 sweep_done SHALL clear on entry to IDLE.

Reset
REQ-027 When rst=1 at a clk_50m edge, the next values SHALL be:
- FSM = IDLE
- freq = 0, pinc = 0, phase = 0, dds_addr = 0
- dds_en = 0, sweep_done = 0, first_pt = 0
- all synchronizer and history flops = 0
REQ-028 Reset mid-sweep SHALL take effect at the next edge, with no completion of the current step.

Configuration
REQ-029 Macro PHASE_RESET_ON_STEP_EN defined: the phase accumulator SHALL load 0 in the same cycle pinc updates after each freq step, so each point starts at phase 0.
REQ-030 Macro PHASE_RESET_ON_STEP_EN undefined: phase SHALL stay continuous across steps, with only pinc changing.

Verification
REQ-031 Reset: rst=1 for 3 cycles, then 0 -> all outputs 0 and FSM in IDLE.
REQ-032 Sweep start: raise learn_en -> freq=1 within 4 cycles; first next_freq pulse -> freq remains 1, pinc=34360, dds_addr advancing.
REQ-033 Stepping: 5 further next_freq pulses (each 20 cycles high, 100 low) -> freq=6, pinc=206160 one cycle after the last step.
REQ-034 Terminal: INDEX_MAX=4, INDEX_STEP=2; pulses -> freq 1, 3, then 4 (saturated), sweep_done=1, dds_en=0; learn_en low -> sweep_done=0, freq=0.
REQ-035 Abort: drop learn_en in RUN at freq=3, aligned with a next_freq rise -> IDLE, freq=0, sweep_done=0.
REQ-036 Macro: with PHASE_RESET_ON_STEP_EN defined -> dds_addr=0 in the cycle after each pinc update; undefined -> dds_addr continues monotonically (mod 1024).

Source files
------------

// File: rtl/sweep_gen.sv
// Frequency sweep generator: steps an FFT bin index on synchronized point requests and
// drives a DDS phase accumulator. Optional macro PHASE_RESET_ON_STEP_EN restarts phase at 0 per point.
module sweep_gen #(
    parameter logic [15:0] INDEX_START  = 16'd1,
    parameter logic [15:0] INDEX_STEP   = 16'd1,
    parameter logic [15:0] INDEX_MAX    = 16'd2751,
    parameter logic [31:0] PINC_PER_BIN = 32'd34360
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        learn_en,
    input  logic        next_freq,
    output logic [15:0] freq,
    output logic [31:0] pinc,
    output logic [9:0]  dds_addr,
    output logic        dds_en,
    output logic        sweep_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic        learn_s1_q, learn_s2_q, learn_h_q;
    logic        nf_s1_q, nf_s2_q, nf_h_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] freq_q, freq_d;
    logic [31:0] pinc_q, pinc_d;
    logic [31:0] phase_q, phase_d;
    logic        first_pt_q, first_pt_d;
    logic        stepped;
    logic [16:0] step_sum;
    logic        learn_rise, learn_fall, nf_rise;

    assign learn_rise = learn_s2_q & ~learn_h_q;
    assign learn_fall = ~learn_s2_q & learn_h_q;
    assign nf_rise    = nf_s2_q & ~nf_h_q;
    // 17-bit sum so a step past 16'hFFFF saturates instead of wrapping
    assign step_sum   = {1'b0, freq_q} + {1'b0, INDEX_STEP};

    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        first_pt_d = first_pt_q;
        stepped    = 1'b0;
        case (state_q)
            S_IDLE: begin
                freq_d     = '0;
                first_pt_d = 1'b0;
                if (learn_rise) state_d = S_ARM;
            end
            S_ARM: begin
                if (learn_fall) begin
                    state_d = S_IDLE;
                    freq_d  = '0;
                end else begin
                    state_d    = S_RUN;
                    freq_d     = INDEX_START;
                    first_pt_d = 1'b1;
                end
            end
            S_RUN: begin
                // abort wins over a coincident point request
                if (learn_fall) begin
                    state_d    = S_IDLE;
                    freq_d     = '0;
                    first_pt_d = 1'b0;
                end else if (nf_rise) begin
                    if (first_pt_q) begin
                        first_pt_d = 1'b0;
                    end else if (step_sum < {1'b0, INDEX_MAX}) begin
                        freq_d  = step_sum[15:0];
                        stepped = 1'b1;
                    end else begin
                        freq_d  = INDEX_MAX;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                freq_d = INDEX_MAX;
                if (learn_fall) begin
                    state_d = S_IDLE;
                    freq_d  = '0;
                end
            end
        endcase
    end

    assign pinc_d = PINC_PER_BIN * {16'd0, freq_q};

`ifdef PHASE_RESET_ON_STEP_EN
    logic step_q;

    always_ff @(posedge clk_50m) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= stepped;
    end

    always_comb begin
        phase_d = '0;
        if (state_q == S_RUN && state_d == S_RUN && !step_q) phase_d = phase_q + pinc_q;
    end
`else
    logic unused_stepped;
    assign unused_stepped = stepped;

    always_comb begin
        phase_d = '0;
        if (state_q == S_RUN && state_d == S_RUN) phase_d = phase_q + pinc_q;
    end
`endif

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            learn_s1_q <= 1'b0;
            learn_s2_q <= 1'b0;
            learn_h_q  <= 1'b0;
            nf_s1_q    <= 1'b0;
            nf_s2_q    <= 1'b0;
            nf_h_q     <= 1'b0;
            state_q    <= S_IDLE;
            freq_q     <= '0;
            pinc_q     <= '0;
            phase_q    <= '0;
            first_pt_q <= 1'b0;
        end else begin
            learn_s1_q <= learn_en;
            learn_s2_q <= learn_s1_q;
            learn_h_q  <= learn_s2_q;
            nf_s1_q    <= next_freq;
            nf_s2_q    <= nf_s1_q;
            nf_h_q     <= nf_s2_q;
            state_q    <= state_d;
            freq_q     <= freq_d;
            pinc_q     <= pinc_d;
            phase_q    <= phase_d;
            first_pt_q <= first_pt_d;
        end
    end

    assign freq       = freq_q;
    assign pinc       = pinc_q;
    assign dds_addr   = phase_q[31:22];
    assign dds_en     = (state_q == S_RUN);
    assign sweep_done = (state_q == S_DONE);

endmodule

// File: tb/tb_sweep_gen.sv
// Self-checking bench for sweep_gen: three parameterizations share one stimulus stream and are
// checked against a pulse-count reference model of the sweep.
module tb_sweep_gen;

    localparam longint PINC = 34360;

    logic clk = 1'b0;
    logic rst, learn_en, next_freq;

    logic [15:0] f0, f1, f2;
    logic [31:0] p0, p1, p2;
    logic [9:0]  a0, a1, a2;
    logic        e0, e1, e2;
    logic        d0, d1, d2;

    int ncmp = 0;
    int nerr = 0;

    longint ST[3] = '{64'd1, 64'd1, 64'hFFF0};
    longint SP[3] = '{64'd1, 64'd2, 64'h20};
    longint MX[3] = '{64'd2751, 64'd4, 64'hFFFF};

    always #10 clk = ~clk;

    sweep_gen u_dflt (
        .clk_50m(clk), .rst(rst), .learn_en(learn_en), .next_freq(next_freq),
        .freq(f0), .pinc(p0), .dds_addr(a0), .dds_en(e0), .sweep_done(d0)
    );

    sweep_gen #(.INDEX_STEP(16'd2), .INDEX_MAX(16'd4)) u_term (
        .clk_50m(clk), .rst(rst), .learn_en(learn_en), .next_freq(next_freq),
        .freq(f1), .pinc(p1), .dds_addr(a1), .dds_en(e1), .sweep_done(d1)
    );

    sweep_gen #(.INDEX_START(16'hFFF0), .INDEX_STEP(16'h0020), .INDEX_MAX(16'hFFFF)) u_wrap (
        .clk_50m(clk), .rst(rst), .learn_en(learn_en), .next_freq(next_freq),
        .freq(f2), .pinc(p2), .dds_addr(a2), .dds_en(e2), .sweep_done(d2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sweep outcome after np point requests: first request only arms stepping, later ones
    // add the step until the next would reach the limit, which saturates and ends the sweep.
    function automatic void model(input int id, input int np, output longint f, output bit done);
        f = ST[id];
        done = 1'b0;
        for (int k = 1; k < np; k++) begin
            if (!done) begin
                if (f + SP[id] < MX[id]) f = f + SP[id];
                else begin
                    f = MX[id];
                    done = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_all(input int np, input bit active);
        longint f;
        bit dn;
        logic [15:0] fo;
        logic [31:0] po;
        logic eo, doo;
        for (int id = 0; id < 3; id++) begin
            model(id, np, f, dn);
            if (!active) begin
                f = 0;
                dn = 1'b0;
            end
            case (id)
                0: begin fo = f0; po = p0; eo = e0; doo = d0; end
                1: begin fo = f1; po = p1; eo = e1; doo = d1; end
                default: begin fo = f2; po = p2; eo = e2; doo = d2; end
            endcase
            chk($sformatf("freq[%0d] np=%0d", id, np), {48'd0, fo}, f);
            chk($sformatf("pinc[%0d] np=%0d", id, np), {32'd0, po}, (f * PINC) & 64'hFFFF_FFFF);
            chk($sformatf("dds_en[%0d] np=%0d", id, np), {63'd0, eo}, {63'd0, active & ~dn});
            chk($sformatf("sweep_done[%0d] np=%0d", id, np), {63'd0, doo}, {63'd0, active & dn});
        end
        if (!active) chk("dds_addr idle", {54'd0, a0}, 64'd0);
    endtask

    // Starts a sweep and issues np point requests; hi_fix/lo_fix of 0 pick random widths.
    task automatic sweep(input int np, input int hi_fix, input int lo_fix);
        int hi, lo;
        longint fa, fb, pexp, lo_exp;
        bit dn, seen;
        logic [9:0] prev, delta, s0;
        learn_en = 1'b1;
        cyc(8);
        check_all(0, 1'b1);
        for (int p = 0; p < np; p++) begin
            hi = (hi_fix != 0) ? hi_fix : int'($urandom_range(20, 6));
            lo = (lo_fix != 0) ? lo_fix : int'($urandom_range(40, 10));
            model(0, p, fa, dn);
            model(0, p + 1, fb, dn);
            pexp = (fb * PINC) & 64'hFFFF_FFFF;
            prev = a0;
            seen = 1'b0;
            next_freq = 1'b1;
            for (int i = 0; i < hi; i++) begin
                cyc(1);
                if (!seen && fb != fa && {32'd0, p0} == pexp) begin
                    seen = 1'b1;
`ifdef PHASE_RESET_ON_STEP_EN
                    chk($sformatf("addr restart p=%0d", p), {54'd0, a0}, 64'd0);
`else
                    delta = a0 - prev;
                    chk($sformatf("addr continuous p=%0d", p), {63'd0, delta <= 10'd1}, 64'd1);
`endif
                end
                prev = a0;
            end
            chk($sformatf("step seen p=%0d", p), {63'd0, seen}, {63'd0, fb != fa});
            next_freq = 1'b0;
            cyc(lo);
            check_all(p + 1, 1'b1);
            // phase advance over a quiet window of 256 cycles, lower phase bits unknown
            s0 = a0;
            cyc(256);
            delta = a0 - s0;
            lo_exp = ((256 * fb * PINC) >> 22) & 1023;
            chk($sformatf("phase advance p=%0d", p),
                {63'd0, (delta == lo_exp[9:0]) || (delta == lo_exp[9:0] + 10'd1)}, 64'd1);
        end
    endtask

    task automatic stop_sweep();
        learn_en = 1'b0;
        cyc(8);
        check_all(0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        learn_en = 1'b0;
        next_freq = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check_all(0, 1'b0);

        // point request while idle is ignored
        next_freq = 1'b1;
        cyc(6);
        next_freq = 1'b0;
        cyc(6);
        check_all(0, 1'b0);

        sweep(6, 20, 100);
        stop_sweep();

        for (int r = 0; r < 3; r++) begin
            sweep(int'($urandom_range(8, 2)), 0, 0);
            stop_sweep();
        end

        // abort coinciding with a point request
        sweep(3, 0, 0);
        chk("abort pre freq", {48'd0, f0}, 64'd3);
        learn_en = 1'b0;
        next_freq = 1'b1;
        cyc(10);
        check_all(0, 1'b0);
        next_freq = 1'b0;
        cyc(10);
        check_all(0, 1'b0);

        // reset in the middle of a sweep
        sweep(2, 0, 0);
        rst = 1'b1;
        learn_en = 1'b0;
        cyc(1);
        check_all(0, 1'b0);
        rst = 1'b0;
        cyc(10);
        check_all(0, 1'b0);

        sweep(2, 0, 0);
        stop_sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
